// File: rtl/stream_pkg.sv
// Shared defaults and FSM state type for the frame streaming blocks.
package stream_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    StIdle,
    StPrefetch,
    StStream,
    StDone
  } frame_state_e;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port, no reset.
module frame_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk_in,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read (read-during-write returns old data).
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_stream_src.sv
// Streams a stored frame of FRAME_LEN samples out on an AXI-Stream-like port.
// Optional macro FRAME_LOOP_EN adds input loop_en for continuous frame replay.
module frame_stream_src
  import stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned FRAME_LEN  = 10
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
`ifdef FRAME_LOOP_EN
  input  logic                  loop_en,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [ADDR_WIDTH-1:0] m_axis_taddr,
  output logic                  m_axis_tlast
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  frame_state_e          state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  loop_active;
  logic                  xfer;
  logic                  at_last;

`ifdef FRAME_LOOP_EN
  assign loop_active = loop_en;
`else
  assign loop_active = 1'b0;
`endif

  assign xfer    = tvalid_q && m_axis_tready;
  assign at_last = (addr_q == LAST_ADDR);

  // Buffer is frozen while a frame is in flight so a frame is never torn.
  assign ram_we = wr_en && (state_q == StIdle);

  frame_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_frame_ram (
    .clk_in (clk_in),
    .wr_en  (ram_we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(addr_d),
    .rd_data(ram_rdata)
  );

  // Next beat index; it doubles as the RAM read address so the read register
  // always holds the sample of the beat being presented (held during stalls).
  always_comb begin
    addr_d = addr_q;
    unique case (state_q)
      StIdle:     addr_d = '0;
      StPrefetch: addr_d = '0;
      StStream: begin
        if (xfer) begin
          addr_d = at_last ? '0 : addr_q + ADDR_WIDTH'(1);
        end
      end
      StDone:     addr_d = '0;
      default:    addr_d = '0;
    endcase
  end

  // Frame sequencing FSM with registered handshake and status outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          addr_q <= '0;
          if (start) begin
            state_q <= StPrefetch;
            busy_q  <= 1'b1;
          end
        end
        StPrefetch: begin
          state_q  <= StStream;
          addr_q   <= addr_d;
          tvalid_q <= 1'b1;
          tlast_q  <= (addr_d == LAST_ADDR);
        end
        StStream: begin
          if (xfer) begin
            if (at_last && !loop_active) begin
              state_q  <= StDone;
              addr_q   <= '0;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              addr_q  <= addr_d;
              tlast_q <= (addr_d == LAST_ADDR);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_taddr  = addr_q;
  assign m_axis_tlast  = tlast_q;
  // RAM read register is the data register; zero whenever no beat is presented.
  assign m_axis_tdata  = tvalid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_frame_stream_src.sv
// Self-checking bench for frame_stream_src (FRAME_LEN=10 and FRAME_LEN=1 instances).
module tb_frame_stream_src;

  typedef struct packed {
    logic [7:0] data;
    logic [5:0] addr;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       tready;
  logic       busy, done, tvalid, tlast;
  logic [7:0] tdata;
  logic [5:0] taddr;
`ifdef FRAME_LOOP_EN
  logic       loop_en;
`endif

  logic       b_wr_en;
  logic [5:0] b_wr_addr;
  logic [7:0] b_wr_data;
  logic       b_start;
  logic       b_tready;
  logic       b_busy, b_done, b_tvalid, b_tlast;
  logic [7:0] b_tdata;
  logic [5:0] b_taddr;

  int checks = 0;
  int errors = 0;

  beat_t      exp_q[$];
  logic [7:0] mem_model [64];

  // Observation log written only by the monitor.
  beat_t obs_arr [1024];
  int    obs_cyc [1024];
  int    obs_n    = 0;
  int    cyc      = 0;
  int    done_cnt = 0;
  int    done_cyc = -1;
  int    hold_cnt = 0;
  int    hold_bad = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  always #5 clk = ~clk;

  frame_stream_src #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(6),
    .FRAME_LEN (10)
  ) dut (
    .clk_in       (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
`ifdef FRAME_LOOP_EN
    .loop_en      (loop_en),
`endif
    .busy         (busy),
    .done         (done),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tdata (tdata),
    .m_axis_taddr (taddr),
    .m_axis_tlast (tlast)
  );

  frame_stream_src #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(6),
    .FRAME_LEN (1)
  ) dut_len1 (
    .clk_in       (clk),
    .rst          (rst),
    .wr_en        (b_wr_en),
    .wr_addr      (b_wr_addr),
    .wr_data      (b_wr_data),
    .start        (b_start),
`ifdef FRAME_LOOP_EN
    .loop_en      (1'b0),
`endif
    .busy         (b_busy),
    .done         (b_done),
    .m_axis_tvalid(b_tvalid),
    .m_axis_tready(b_tready),
    .m_axis_tdata (b_tdata),
    .m_axis_taddr (b_taddr),
    .m_axis_tlast (b_tlast)
  );

  // Monitor: log transfers, done pulses and stall holds, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tvalid === 1'b1 && tready === 1'b1 && obs_n < 1024) begin
      obs_arr[obs_n] = '{data: tdata, addr: taddr, last: tlast};
      obs_cyc[obs_n] = cyc;
      obs_n = obs_n + 1;
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (prev_stall && (tvalid !== 1'b1 || {tdata, taddr, tlast} !== prev_beat)) begin
      hold_bad = hold_bad + 1;
    end
    if (tvalid === 1'b1 && tready === 1'b0) hold_cnt = hold_cnt + 1;
    prev_stall = (tvalid === 1'b1 && tready === 1'b0);
    prev_beat  = '{data: tdata, addr: taddr, last: tlast};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input logic [7:0] v [10]);
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = v[i];
      mem_model[i] = v[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{data: mem_model[i], addr: 6'(i), last: (i == 9)});
    end
  endtask

  task automatic wait_beat(input int a, output bit found);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (tvalid === 1'b1 && taddr == 6'(a)) found = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; tready = 1'b1;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_start = 1'b0; b_tready = 1'b1;
`ifdef FRAME_LOOP_EN
    loop_en = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({tvalid, tlast, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {tvalid, tlast, busy, done});
    end
    checks++;
    if ({tdata, taddr} !== 14'h0) begin
      errors++; $display("FAIL reset_data got data=%h addr=%h want 0", tdata, taddr);
    end
    checks++;
    if ({b_tvalid, b_tlast, b_busy, b_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_len1 got %b want 0000", {b_tvalid, b_tlast, b_busy, b_done});
    end
  endtask

  task automatic test_basic();
    logic [7:0] v [10] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2};
    int base, d0, n_exp;
    beat_t e;
    load_frame(v);
    base = obs_n; d0 = done_cnt;
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({busy, tvalid} !== 2'b10) begin
      errors++; $display("FAIL basic_prefetch got busy,tvalid=%b want 10", {busy, tvalid});
    end
    tick();
    checks++;
    if ({tvalid, taddr, tdata} !== {1'b1, 6'd0, 8'd1}) begin
      errors++; $display("FAIL basic_first got v=%b a=%0d d=%h want 1 0 01", tvalid, taddr, tdata);
    end
    repeat (16) tick();
    n_exp = exp_q.size();
    checks++;
    if (obs_n - base != n_exp) begin
      errors++; $display("FAIL basic_count got %0d want %0d", obs_n - base, n_exp);
    end
    for (int k = 0; k < n_exp; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_arr[base+k] !== e || obs_cyc[base+k] != obs_cyc[base] + k) begin
        errors++;
        $display("FAIL basic_beat%0d got %h cyc+%0d want %h cyc+%0d", k, obs_arr[base+k],
                 obs_cyc[base+k] - obs_cyc[base], e, k);
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || done_cyc != obs_cyc[base+9] + 1) begin
      errors++; $display("FAIL basic_done got pulses=%0d cyc=%0d want 1 cyc=%0d",
                         done_cnt - d0, done_cyc, obs_cyc[base+9] + 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_end got %b want 0", busy);
    end
  endtask

  task automatic test_stall();
    int base, h0, b0, n_exp;
    bit found;
    beat_t e;
    base = obs_n; h0 = hold_cnt; b0 = hold_bad;
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    wait_beat(4, found);
    checks++;
    if (!found) begin
      errors++; $display("FAIL stall_reach got no beat 4 want beat 4");
    end
    tready = 1'b0; repeat (3) tick(); tready = 1'b1;
    repeat (12) tick();
    checks++;
    if (hold_cnt - h0 != 3 || hold_bad != b0) begin
      errors++; $display("FAIL stall_hold got held=%0d unstable=%0d want 3 0",
                         hold_cnt - h0, hold_bad - b0);
    end
    n_exp = exp_q.size();
    checks++;
    if (obs_n - base != n_exp) begin
      errors++; $display("FAIL stall_count got %0d want %0d", obs_n - base, n_exp);
    end
    for (int k = 0; k < n_exp; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_arr[base+k] !== e) begin
        errors++; $display("FAIL stall_beat%0d got %h want %h", k, obs_arr[base+k], e);
      end
    end
  endtask

  // start and a buffer write both arrive mid-frame; both must be ignored.
  task automatic test_busy_inputs();
    int base, d0, n_exp;
    bit found;
    beat_t e;
    base = obs_n; d0 = done_cnt;
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    wait_beat(2, found);
    start = 1'b1; wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'hEE;
    tick();
    start = 1'b0; wr_en = 1'b0;
    repeat (20) tick();
    n_exp = exp_q.size();
    checks++;
    if (!found || obs_n - base != n_exp) begin
      errors++; $display("FAIL restart_count got %0d want %0d", obs_n - base, n_exp);
    end
    for (int k = 0; k < n_exp; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_arr[base+k] !== e) begin
        errors++; $display("FAIL restart_beat%0d got %h want %h", k, obs_arr[base+k], e);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL restart_done got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_abort();
    int base, d0, n_exp;
    bit found;
    beat_t e;
    base = obs_n; d0 = done_cnt;
    for (int i = 0; i < 7; i++) exp_q.push_back('{data: mem_model[i], addr: 6'(i), last: 1'b0});
    start = 1'b1; tick(); start = 1'b0;
    wait_beat(6, found);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (!found || {tvalid, tlast, done, busy} !== 4'b0000) begin
      errors++; $display("FAIL abort_ctrl got %b want 0000", {tvalid, tlast, done, busy});
    end
    repeat (3) tick();
    checks++;
    if (done_cnt != d0) begin
      errors++; $display("FAIL abort_done got %0d want 0", done_cnt - d0);
    end
    n_exp = exp_q.size();
    checks++;
    if (obs_n - base != n_exp) begin
      errors++; $display("FAIL abort_count got %0d want %0d", obs_n - base, n_exp);
    end
    for (int k = 0; k < n_exp; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_arr[base+k] !== e) begin
        errors++; $display("FAIL abort_beat%0d got %h want %h", k, obs_arr[base+k], e);
      end
    end
    // Replay: buffer survived both the reset and the ignored write.
    base = obs_n;
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    repeat (16) tick();
    n_exp = exp_q.size();
    checks++;
    if (obs_n - base != n_exp) begin
      errors++; $display("FAIL replay_count got %0d want %0d", obs_n - base, n_exp);
    end
    for (int k = 0; k < n_exp; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_arr[base+k] !== e) begin
        errors++; $display("FAIL replay_beat%0d got %h want %h", k, obs_arr[base+k], e);
      end
    end
  endtask

  task automatic test_write_with_start();
    int base;
    base = obs_n;
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = 8'hAA; start = 1'b1;
    mem_model[0] = 8'hAA;
    tick();
    wr_en = 1'b0; start = 1'b0;
    repeat (16) tick();
    checks++;
    if (obs_n - base != 10 || obs_arr[base] !== beat_t'{data: 8'hAA, addr: 6'd0, last: 1'b0}) begin
      errors++; $display("FAIL wrstart_first got %h n=%0d want aa000 n=10", obs_arr[base],
                         obs_n - base);
    end
  endtask

  task automatic test_len1();
    b_wr_en = 1'b1; b_wr_addr = 6'd0; b_wr_data = 8'h7F; tick(); b_wr_en = 1'b0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    checks++;
    if ({b_busy, b_tvalid} !== 2'b10) begin
      errors++; $display("FAIL len1_prefetch got %b want 10", {b_busy, b_tvalid});
    end
    tick();
    checks++;
    if ({b_tvalid, b_tlast, b_taddr, b_tdata} !== {1'b1, 1'b1, 6'd0, 8'h7F}) begin
      errors++; $display("FAIL len1_beat got v=%b l=%b a=%0d d=%h want 1 1 0 7f",
                         b_tvalid, b_tlast, b_taddr, b_tdata);
    end
    tick();
    checks++;
    if ({b_done, b_tvalid, b_busy} !== 3'b100) begin
      errors++; $display("FAIL len1_done got %b want 100", {b_done, b_tvalid, b_busy});
    end
    tick();
    checks++;
    if (b_done !== 1'b0) begin
      errors++; $display("FAIL len1_done_width got %b want 0", b_done);
    end
  endtask

`ifdef FRAME_LOOP_EN
  task automatic test_loop();
    int base, d0, n_exp;
    beat_t e;
    base = obs_n; d0 = done_cnt;
    for (int k = 0; k < 30; k++) begin
      exp_q.push_back('{data: mem_model[k % 10], addr: 6'(k % 10), last: (k % 10 == 9)});
    end
    loop_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 60 && obs_n - base < 25; c++) tick();
    checks++;
    if (done_cnt != d0 || busy !== 1'b1) begin
      errors++; $display("FAIL loop_nodone got pulses=%0d busy=%b want 0 1", done_cnt - d0, busy);
    end
    loop_en = 1'b0;
    repeat (12) tick();
    n_exp = exp_q.size();
    checks++;
    if (obs_n - base != n_exp) begin
      errors++; $display("FAIL loop_count got %0d want %0d", obs_n - base, n_exp);
    end
    for (int k = 0; k < n_exp; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_arr[base+k] !== e || obs_cyc[base+k] != obs_cyc[base] + k) begin
        errors++; $display("FAIL loop_beat%0d got %h want %h", k, obs_arr[base+k], e);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL loop_done got %0d want 1", done_cnt - d0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_busy_inputs();
    test_reset_abort();
    test_write_with_start();
    test_len1();
`ifdef FRAME_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
